// File: rtl/data_mem_mmio_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_mmio_pkg
// Shared constants for the data-side memory subsystem:
//   - MMIO register offsets within the MMIO page (dataAddr[7:0])
//   - bit positions inside TIMER_CTRL and TX_STATUS
// ---------------------------------------------------------------------------
package data_mem_mmio_pkg;

  // MMIO register offsets
  localparam logic [7:0] OFF_CYCLE_LO = 8'h00;
  localparam logic [7:0] OFF_CYCLE_HI = 8'h01;
  localparam logic [7:0] OFF_TLOAD    = 8'h02;
  localparam logic [7:0] OFF_TCTRL    = 8'h03;
  localparam logic [7:0] OFF_TCOUNT   = 8'h04;
  localparam logic [7:0] OFF_TXDATA   = 8'h08;
  localparam logic [7:0] OFF_TXSTAT   = 8'h09;

  // TIMER_CTRL bit positions
  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_AR   = 1;
  localparam int TCTRL_PEND = 2;

  // TX_STATUS bit positions
  localparam int TXS_FULL  = 0;
  localparam int TXS_EMPTY = 1;
  localparam int TXS_OVF   = 2;

endpackage

// File: rtl/data_mem_mmio_if.sv
// ---------------------------------------------------------------------------
// data_mem_mmio_if
// Bundles the cpu data port and the TX byte stream of data_mem_mmio.
//   MemRd/MemWr   : read / write strobes from the cpu
//   dataAddr      : 16-bit word address
//   datain        : write data
//   dataout       : combinational read data (0 when MemRd = 0)
//   tx_valid/tx_data/tx_ready : TX FIFO output handshake
//   timer_irq     : timer pending flag
// master = cpu / consumer side, slave = the memory subsystem.
// ---------------------------------------------------------------------------
interface data_mem_mmio_if;
  logic        MemRd;
  logic        MemWr;
  logic [15:0] dataAddr;
  logic [15:0] datain;
  logic [15:0] dataout;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        timer_irq;

  modport master (
    output MemRd, MemWr, dataAddr, datain, tx_ready,
    input  dataout, tx_valid, tx_data, timer_irq
  );

  modport slave (
    input  MemRd, MemWr, dataAddr, datain, tx_ready,
    output dataout, tx_valid, tx_data, timer_irq
  );
endinterface

// File: rtl/data_mem_mmio_byte_fifo.sv
// ---------------------------------------------------------------------------
// data_mem_mmio_byte_fifo
// Circular byte FIFO with one extra pointer bit to tell full from empty.
//   clk, reset : clock, async active-high reset (empties the FIFO)
//   push, din  : push request and byte
//   pop        : pop request (ignored when empty)
//   push_ok    : push accepted this cycle (not full, or a pop frees a slot)
//   full/empty : occupancy flags
//   head       : oldest byte, 0 when empty
// ---------------------------------------------------------------------------
module data_mem_mmio_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       push_ok,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // When full, a simultaneous pop frees the slot being written; the head is
  // read combinationally before the edge, so the overwrite is safe.
  assign do_pop  = pop && !empty;
  assign push_ok = push && (!full || do_pop);

  assign head = empty ? 8'h00 : mem[rd_ptr[PW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage arrays are deliberately not reset; the pointers alone
  // define which entries are valid, and head masks the empty case.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/data_mem_mmio.sv
// ---------------------------------------------------------------------------
// data_mem_mmio
// Data-side memory subsystem: word RAM in the low region, MMIO page with a
// cycle counter, a down-counting timer and a TX byte FIFO.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : data_mem_mmio_if.slave (cpu data port, TX stream, timer_irq)
// Reads are combinational and show pre-write values; all state changes
// (writes and read side effects) happen at the clock edge.
// ---------------------------------------------------------------------------
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int         RAM_AW    = 10,
  parameter int         TX_DEPTH  = 4,
  parameter logic [7:0] MMIO_PAGE = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  data_mem_mmio_if.slave   bus
);

  // ---------------- decode ----------------
  logic              mmio;
  logic [7:0]        off;
  logic [RAM_AW-1:0] ram_idx;
  logic              mmio_wr;
  logic              mmio_rd;

  assign mmio    = (bus.dataAddr[15:8] == MMIO_PAGE);
  assign off     = bus.dataAddr[7:0];
  assign ram_idx = bus.dataAddr[RAM_AW-1:0];   // upper bits ignored: RAM aliases
  assign mmio_wr = bus.MemWr && mmio;
  assign mmio_rd = bus.MemRd && mmio;

  logic wr_tload, wr_tctrl, wr_txdata, wr_txstat, rd_cyclo;
  assign wr_tload  = mmio_wr && (off == OFF_TLOAD);
  assign wr_tctrl  = mmio_wr && (off == OFF_TCTRL);
  assign wr_txdata = mmio_wr && (off == OFF_TXDATA);
  assign wr_txstat = mmio_wr && (off == OFF_TXSTAT);
  assign rd_cyclo  = mmio_rd && (off == OFF_CYCLE_LO);

  // ---------------- RAM ----------------
  logic [15:0] ram [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (bus.MemWr && !mmio) ram[ram_idx] <= bus.datain;
  end

  // ---------------- cycle counter ----------------
  logic [31:0] cycle;
  logic [15:0] hi_snap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle   <= '0;
      hi_snap <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      // Snapshot the upper half so a LO-then-HI read pair is coherent.
      if (rd_cyclo) hi_snap <= cycle[31:16];
    end
  end

  // ---------------- timer ----------------
  logic [15:0] tload;
  logic [15:0] tcount;
  logic        t_en;
  logic        t_ar;
  logic        t_pend;
  logic        expire;

  assign expire = t_en && (tcount == 16'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tload  <= '0;
      tcount <= '0;
      t_en   <= 1'b0;
      t_ar   <= 1'b0;
      t_pend <= 1'b0;
    end else begin
      // A TIMER_LOAD write takes priority over decrement and reload.
      if (wr_tload) begin
        tload  <= bus.datain;
        tcount <= bus.datain;
      end else if (t_en) begin
        if (tcount != 16'd0) tcount <= tcount - 16'd1;
        else if (t_ar)       tcount <= tload;
      end

      // An explicit control write wins over the one-shot self-disable.
      if (wr_tctrl) begin
        t_en <= bus.datain[TCTRL_EN];
        t_ar <= bus.datain[TCTRL_AR];
      end else if (expire && !t_ar) begin
        t_en <= 1'b0;
      end

      // Expiry beats a same-cycle write-1-to-clear so no event is lost.
      if (expire)                                 t_pend <= 1'b1;
      else if (wr_tctrl && bus.datain[TCTRL_PEND]) t_pend <= 1'b0;
    end
  end

  assign bus.timer_irq = t_pend;

  // ---------------- TX FIFO ----------------
  logic       fifo_push_ok;
  logic       fifo_full;
  logic       fifo_empty;
  logic       tx_overflow;
  logic [7:0] fifo_head;

  data_mem_mmio_byte_fifo #(.DEPTH(TX_DEPTH)) u_byte_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_txdata),
    .din     (bus.datain[7:0]),
    .pop     (bus.tx_ready),
    .push_ok (fifo_push_ok),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_overflow <= 1'b0;
    end else if (wr_txdata && !fifo_push_ok) begin
      tx_overflow <= 1'b1;
    end else if (wr_txstat && bus.datain[TXS_OVF]) begin
      tx_overflow <= 1'b0;
    end
  end

  // ---------------- read mux ----------------
  logic [15:0] tctrl_val;
  logic [15:0] txstat_val;
  logic [15:0] rd_val;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    tctrl_val             = '0;
    tctrl_val[TCTRL_EN]   = t_en;
    tctrl_val[TCTRL_AR]   = t_ar;
    tctrl_val[TCTRL_PEND] = t_pend;

    txstat_val            = '0;
    txstat_val[TXS_FULL]  = fifo_full;
    txstat_val[TXS_EMPTY] = fifo_empty;
    txstat_val[TXS_OVF]   = tx_overflow;

    rd_val = '0;
    if (mmio) begin
      case (off)
        OFF_CYCLE_LO: rd_val = cycle[15:0];
        OFF_CYCLE_HI: rd_val = hi_snap;
        OFF_TLOAD:    rd_val = tload;
        OFF_TCTRL:    rd_val = tctrl_val;
        OFF_TCOUNT:   rd_val = tcount;
        OFF_TXSTAT:   rd_val = txstat_val;
        default:      rd_val = '0;   // includes write-only TX_DATA
      endcase
    end else begin
      rd_val = ram[ram_idx];
    end
  end

  assign bus.dataout = bus.MemRd ? rd_val : 16'h0000;

endmodule
